// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer
//  Description : Sequencing controller for the shift-add signed multiplier
//                datapath. A rising edge on Run starts one multiply: clear
//                X/A, then N_BITS iterations of (add|sub)+shift, then Done.
//                Optional macro MULT_SEQ_SKIP_ZERO_EN folds the shift into
//                the ADD cycle when M = 0, which shortens zero-bit
//                iterations to a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
    parameter int N_BITS = 8
) (
    input  logic                      Clk,
    input  logic                      Reset_Load_Clear,
    input  logic                      Run,
    input  logic                      Load_B,
    input  logic                      M,
    output logic                      Clr_XA,
    output logic                      Ld_B,
    output logic                      Add_En,
    output logic                      Sub_En,
    output logic                      Shift_En,
    output logic                      Busy,
    output logic                      Done,
    output logic [$clog2(N_BITS)-1:0] Count
);

    localparam int c_CNT_W = $clog2(N_BITS);

    // State encoding
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_ADD   = 3'd2;
    localparam logic [2:0] c_SHIFT = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    // Index of the final iteration; the sign-bit weight is subtracted there
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N_BITS - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic               r_run_q;
    logic               w_start;
    logic               w_last;
    logic               w_cnt_inc;

    // Only a 0->1 transition of Run starts a multiply
    assign w_start = Run & ~r_run_q;
    assign w_last  = (r_count == c_LAST);

    // Count advances after each completed iteration except the final one,
    // so it never wraps and holds its last value while in DONE
`ifdef MULT_SEQ_SKIP_ZERO_EN
    assign w_cnt_inc = ~w_last & ((r_state == c_SHIFT) | ((r_state == c_ADD) & ~M));
`else
    assign w_cnt_inc = ~w_last & (r_state == c_SHIFT);
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_Load_Clear) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run edge-detect history; cleared on reset so a Run held high through
    // reset release still counts as a start
    always_ff @(posedge Clk) begin
        if (!Reset_Load_Clear) begin
            r_run_q <= 1'b0;
        end else begin
            r_run_q <= Run;
        end
    end

    // Iteration counter: cleared in CLEAR, incremented between iterations
    always_ff @(posedge Clk) begin
        if (!Reset_Load_Clear) begin
            r_count <= '0;
        end else if (r_state == c_CLEAR) begin
            r_count <= '0;
        end else if (w_cnt_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_CLEAR;
                end
            end
            c_CLEAR: begin
                w_state_nxt = c_ADD;
            end
            c_ADD: begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
                // A zero multiplier bit needs no add, so the shift happens
                // here and the separate SHIFT cycle is skipped
                if (M) begin
                    w_state_nxt = c_SHIFT;
                end else if (w_last) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_state_nxt = c_ADD;
                end
`else
                w_state_nxt = c_SHIFT;
`endif
            end
            c_SHIFT: begin
                w_state_nxt = w_last ? c_DONE : c_ADD;
            end
            c_DONE: begin
                // Wait for Run release so one press yields one multiply
                if (!Run) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output decode: Busy/Done/Count from state, strobes qualified by M/Load_B
    always_comb begin
        Clr_XA   = 1'b0;
        Ld_B     = 1'b0;
        Add_En   = 1'b0;
        Sub_En   = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (r_state)
            c_IDLE: begin
                Ld_B = Load_B;
            end
            c_CLEAR: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            c_ADD: begin
                Busy = 1'b1;
                // Two's-complement: the MSB of B carries negative weight
                if (M) begin
                    Add_En = ~w_last;
                    Sub_En = w_last;
                end
`ifdef MULT_SEQ_SKIP_ZERO_EN
                else begin
                    Shift_En = 1'b1;
                end
`endif
            end
            c_SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
            end
            c_DONE: begin
                Done = 1'b1;
                Ld_B = Load_B;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    assign Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_sequencer
//  Description : Scoreboard bench for mult_sequencer. A small behavioural
//                X:A:B datapath is driven by the DUT strobes; each multiply
//                pushes its hand-computed product, strobe counts and latency,
//                and a monitor compares them when Done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_Load_Clear;
    logic       Run;
    logic       Load_B;
    logic       M;
    logic       Clr_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done;
    logic [2:0] Count;

    // Behavioural datapath
    logic       dp_x = 1'b0;
    logic [7:0] dp_a = 8'h00;
    logic [7:0] dp_b = 8'h00;
    logic [7:0] sw   = 8'h00;
    logic [7:0] dp_s = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [16:0] prod;
        int          lat;
        int          adds;
        int          subs;
        int          c0;
    } exp_t;

    exp_t exp_q[$];

    mult_sequencer #(.N_BITS(8)) dut (
        .Clk              (Clk),
        .Reset_Load_Clear (Reset_Load_Clear),
        .Run              (Run),
        .Load_B           (Load_B),
        .M                (M),
        .Clr_XA           (Clr_XA),
        .Ld_B             (Ld_B),
        .Add_En           (Add_En),
        .Sub_En           (Sub_En),
        .Shift_En         (Shift_En),
        .Busy             (Busy),
        .Done             (Done),
        .Count            (Count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    assign M = dp_b[0];

    // Datapath reacting to the strobes
    always @(posedge Clk) begin
        if (Clr_XA) begin
            dp_x <= 1'b0;
            dp_a <= 8'h00;
        end else if (Ld_B) begin
            dp_b <= sw;
        end else if (Add_En) begin
            {dp_x, dp_a} <= {dp_x, dp_a} + {dp_s[7], dp_s};
        end else if (Sub_En) begin
            {dp_x, dp_a} <= {dp_x, dp_a} - {dp_s[7], dp_s};
        end else if (Shift_En) begin
            {dp_x, dp_a, dp_b} <= {dp_x, dp_x, dp_a, dp_b[7:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor
    initial begin : monitor
        int   adds, subs, shifts, clrs, multi, nstb;
        logic prev_done;
        exp_t e;
        adds = 0; subs = 0; shifts = 0; clrs = 0; multi = 0; prev_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset_Load_Clear !== 1'b1) begin
                adds = 0; subs = 0; shifts = 0; clrs = 0; multi = 0; prev_done = 1'b0;
            end else begin
                nstb = int'(Clr_XA) + int'(Ld_B) + int'(Add_En) + int'(Sub_En) + int'(Shift_En);
                if (nstb > 1) multi++;
                adds   += int'(Add_En);
                subs   += int'(Sub_En);
                shifts += int'(Shift_En);
                clrs   += int'(Clr_XA);
                if (Done && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("product",   {15'd0, dp_x, dp_a, dp_b}, {15'd0, e.prod});
                        chk("latency",   cyc - e.c0 + 1, e.lat);
                        chk("add_count", adds, e.adds);
                        chk("sub_count", subs, e.subs);
                        chk("shift_cnt", shifts, 8);
                        chk("clr_count", clrs, 1);
                        chk("multi_stb", multi, 0);
                    end
                    adds = 0; subs = 0; shifts = 0; clrs = 0; multi = 0;
                end
                prev_done = Done;
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Done) break;
        end
        if (!Done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input logic [2:0] val);
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Count == val) break;
        end
        chk("wait_count", {29'd0, Count}, {29'd0, val});
    endtask

    task automatic push_exp(input logic [16:0] prod, input int adds, input int subs,
                            input int lat_fixed, input int lat_skip);
        exp_t e;
        e.prod = prod;
        e.adds = adds;
        e.subs = subs;
`ifdef MULT_SEQ_SKIP_ZERO_EN
        e.lat  = lat_skip;
`else
        e.lat  = lat_fixed;
`endif
        e.c0   = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Load B from the switches while idle
    task automatic load_b(input logic [7:0] b, input logic check_ld);
        sw     = b;
        Load_B = 1'b1;
        #2;
        if (check_ld) chk("ld_b_idle", {31'd0, Ld_B}, 32'd1);
        tick();
        Load_B = 1'b0;
    endtask

    // One multiply with a single-cycle Run pulse
    task automatic run_vec(input logic [7:0] b, input logic [7:0] s, input logic [16:0] prod,
                           input int adds, input int subs, input int lat_skip);
        dp_s = s;
        load_b(b, 1'b0);
        Run = 1'b1;
        push_exp(prod, adds, subs, 18, lat_skip);
        tick();
        Run = 1'b0;
        wait_done();
        tick();
        tick();
    endtask

    initial begin : stim
        int bad;
        Reset_Load_Clear = 1'b0;
        Run    = 1'b0;
        Load_B = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {25'd0, Clr_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done}, 32'd0);
        chk("reset_count", {29'd0, Count}, 32'd0);
        Reset_Load_Clear = 1'b1;
        tick();

        // Basic multiply 7 * 3 with the IDLE Load_B check
        dp_s = 8'h03;
        load_b(8'h07, 1'b1);
        Run = 1'b1;
        push_exp(17'h00015, 3, 0, 18, 13);
        tick();
        Run = 1'b0;
        wait_done();
        tick();
        tick();

        // Signed: -123 * -59 = 7257
        run_vec(8'h85, 8'hC5, 17'h01C59, 2, 1, 13);

        // Load_B during iteration 3 must be ignored
        dp_s = 8'h05;
        load_b(8'h01, 1'b0);
        Run = 1'b1;
        push_exp(17'h00005, 1, 0, 18, 11);
        tick();
        Run = 1'b0;
        wait_count(3'd3);
        sw     = 8'hAA;
        Load_B = 1'b1;
        #1;
        chk("ld_b_gated", {31'd0, Ld_B}, 32'd0);
        chk("busy_mid_op", {31'd0, Busy}, 32'd1);
        tick();
        Load_B = 1'b0;
        wait_done();
        tick();
        tick();

        // Reset during iteration 4, then restart: -1 * 2 = -2
        dp_s = 8'h02;
        load_b(8'hFF, 1'b0);
        Run = 1'b1;
        tick();
        Run = 1'b0;
        wait_count(3'd4);
        tick();
        Reset_Load_Clear = 1'b0;
        tick();
        Reset_Load_Clear = 1'b1;
        chk("abort_outputs", {25'd0, Clr_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done}, 32'd0);
        chk("abort_count", {29'd0, Count}, 32'd0);
        tick();
        chk("abort_stays_idle", {30'd0, Busy, Done}, 32'd0);
        run_vec(8'hFF, 8'h02, 17'h1FFFE, 7, 1, 18);

        // Held Run: 127 * -128, one multiply, Done held until release
        dp_s = 8'h7F;
        load_b(8'h80, 1'b0);
        Run = 1'b1;
        push_exp(17'h1C080, 0, 1, 18, 11);
        tick();
        wait_done();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (cyc - exp_q.size() >= 0 && !Done) bad++;
            if (Clr_XA || Busy) bad++;
            @(negedge Clk);
            if (cyc >= 40 + (cyc - cyc % 1) - (cyc - cyc % 1) && i >= 22) break;
        end
        chk("held_run_done", bad, 0);
        tick();
        Run = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("release_idle", {30'd0, Busy, Done}, 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (Clr_XA || Busy) bad++;
        end
        chk("no_second_clear", bad, 0);
        tick();

        // Load_B and Run edge in the same IDLE cycle: 3 * -3 = -9
        dp_s   = 8'hFD;
        sw     = 8'h03;
        Load_B = 1'b1;
        Run    = 1'b1;
        push_exp(17'h1FFF7, 2, 0, 18, 12);
        #1;
        chk("ld_b_with_start", {31'd0, Ld_B}, 32'd1);
        tick();
        Load_B = 1'b0;
        Run    = 1'b0;
        wait_done();
        tick();
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_sequencer.md
# mult_sequencer

Sequencing controller for the 8-bit shift-add multiplier datapath (X flip-flop, A and B registers, add/sub unit). It converts a Run press into one complete signed multiply. It issues clear, add, subtract and shift strobes for exactly eight iterations and reports completion through a Busy/Done handshake. It sits between the board-level input synchronizers and the datapath, and replaces ad-hoc enable wiring at the multiplier top level.

## Interface
Parameters:
- N_BITS, default 8: number of iterations (operand width). Legal range 2–16.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset_Load_Clear  input  1  synchronous, active-low reset. Sampled only on the rising edge of Clk.
- Run  input  1  active-high start request, already synchronized. A multiply starts on a 0→1 edge only.
- Load_B  input  1  active-high request to load the B register from the switches.
- M  input  1  current LSB of the B register.
- Clr_XA  output  1  clears the X and A registers.
- Ld_B  output  1  load strobe for the B register.
- Add_En  output  1  A ← A + S; X ← sign of the result.
- Sub_En  output  1  A ← A − S; X ← sign of the result.
- Shift_En  output  1  arithmetic right shift of X:A:B.
- Busy  output  1  high from CLEAR through the final iteration.
- Done  output  1  high while in DONE.
- Count  output  $clog2(N_BITS)  index of the current iteration.

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, DONE.
- Edge detect: a registered copy Run_q is kept. The start condition is Run & ~Run_q.
- IDLE:
  - Start condition → go to CLEAR.
  - Ld_B = Load_B.
  - All other strobes are 0.
- CLEAR:
  - Clr_XA = 1, Count ← 0.
  - Unconditionally go to ADD.
- ADD (iteration k = Count):
  - If M = 1: assert Sub_En when k = N_BITS−1, otherwise assert Add_En. Next state is SHIFT.
  - If M = 0: no add/sub strobe. Next state is SHIFT (behaviour with the macro differs, see Configuration).
- SHIFT:
  - Shift_En = 1.
  - If Count = N_BITS−1, go to DONE. Otherwise Count ← Count+1 and go to ADD.
- DONE:
  - Done = 1, Ld_B = Load_B.
  - Go to IDLE when Run = 0. While Run stays high, remain in DONE, so one press gives exactly one multiply.
- Strobe exclusivity: at most one of Clr_XA, Ld_B, Add_En, Sub_En, Shift_En is high in any cycle.
- Load_B is ignored outside IDLE and DONE.
- Run deasserting mid-operation has no effect.
- Count never wraps inside an operation. It holds its last value in DONE and is cleared only in CLEAR or by reset.

## Timing
- Reset: a cycle with Reset_Load_Clear = 0 at the rising edge forces the following:
  - state ← IDLE, Count ← 0, Run_q ← 0;
  - all outputs 0 the next cycle.
  - This applies in every state, including mid-operation. No strobes are asserted after the reset edge.
- Outputs: Busy, Done and Count are Moore outputs. Add_En, Sub_En and Ld_B are Mealy outputs, combinational from M or Load_B plus the state.
- Latency, with the start edge sampled at edge E0:
  - CLEAR occupies cycle 1.
  - Iterations occupy cycles 2 to 2N_BITS+1.
  - Done rises in cycle 2N_BITS+2, i.e. cycle 18 for N_BITS = 8.
- Run held high from reset release: Run_q starts at 0, so this counts as a start edge.
- Simultaneous Run edge and Load_B in IDLE: Ld_B is asserted in that cycle and the FSM moves to CLEAR. B is loaded before the first ADD.

## Configuration
- MULT_SEQ_SKIP_ZERO_EN undefined: every iteration costs ADD plus SHIFT. Latency is fixed at 2N_BITS+2 cycles to Done.
- MULT_SEQ_SKIP_ZERO_EN defined: in ADD with M = 0:
  - Shift_En is asserted in that same cycle.
  - Count advances, and the next state is ADD, or DONE after the last iteration.
  - Latency to Done becomes N_BITS + popcount(B) + 2 cycles.
  - Strobe exclusivity still holds.

## Test plan
- Reset mid-operation: hold Reset_Load_Clear = 0 for 1 cycle during iteration 4 → outputs all 0 next cycle, state IDLE, Count = 0. A new Run edge restarts from CLEAR.
- Basic multiply: B = 0x07, S = 0x03, Run 0→1 → Clr_XA for 1 cycle, then Add_En in iterations 0–2 and 8 Shift_En pulses. Done rises at cycle 18. The datapath reads A:B = 0x0015.
- Signed multiply: B = 0x85, S = 0xC5 → Sub_En asserted only in iteration 7. Product X:A:B sign-correct: 0x1C59 (−59 × −123 = 7257).
- Held Run: keep Run high for 40 cycles → exactly one multiply and Done held. Release Run → IDLE the next cycle. No second CLEAR.
- Load gating: pulse Load_B in IDLE → Ld_B = 1 the same cycle. Pulse Load_B during iteration 3 → Ld_B stays 0.
- With MULT_SEQ_SKIP_ZERO_EN, B = 0x01 → Done at cycle 11 (8+1+2). Exactly one Add_En, 8 Shift_En, and no cycle with two strobes.
